// File: rtl/wide_alu_ctrl.sv
// Control sequencer for the wide ALU: latches op/de-accel settings, issues datapath starts,
// waits for completion with a timeout, stretches the result commit and reports status/errors.
module wide_alu_ctrl #(
    parameter int OP_SEL_WIDTH   = 3,
    parameter int NUM_OPS        = 5,
    parameter int DEACCEL_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     trigger_i,
    input  logic                     clear_err_i,
    input  logic                     op_sel_we_i,
    input  logic [OP_SEL_WIDTH-1:0]  op_sel_i,
    output logic [OP_SEL_WIDTH-1:0]  op_sel_o,
    input  logic                     deaccel_factor_we_i,
    input  logic [DEACCEL_WIDTH-1:0] deaccel_factor_i,
    output logic [DEACCEL_WIDTH-1:0] deaccel_factor_o,
    output logic                     dp_start_o,
    output logic [OP_SEL_WIDTH-1:0]  dp_op_o,
    output logic                     dp_abort_o,
    input  logic                     dp_valid_i,
    input  logic                     dp_err_i,
    output logic                     result_we_o,
    output logic [1:0]               status_o,
    output logic [2:0]               err_code_o
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]          TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DEACCEL_WIDTH-1:0] D_ONE   = DEACCEL_WIDTH'(1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_ERROR = 2'b10;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_BUSY    = 3'd2;
    localparam logic [2:0] ERR_DP      = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DP,
        S_DELAY,
        S_ERROR
    } state_e;

    function automatic logic op_legal(input logic [OP_SEL_WIDTH-1:0] op);
        return int'(op) < NUM_OPS;
    endfunction

    state_e                   state_q;
    logic [OP_SEL_WIDTH-1:0]  op_sel_q;
    logic [DEACCEL_WIDTH-1:0] deaccel_q;
    logic [DEACCEL_WIDTH-1:0] delay_cnt_q;
    logic [TO_W-1:0]          to_cnt_q;
    logic                     busy_viol_q;
    logic                     busy_viol_d;
    logic [2:0]               err_code_q;
    logic [1:0]               status_q;
    logic                     dp_start_q;
    logic                     result_we_q;
    logic                     dp_abort_q;

    // Any register access or trigger while an operation is in flight is a violation.
    assign busy_viol_d = busy_viol_q | trigger_i | op_sel_we_i | deaccel_factor_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_sel_q    <= '0;
            deaccel_q   <= '0;
            delay_cnt_q <= '0;
            to_cnt_q    <= '0;
            busy_viol_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            status_q    <= ST_IDLE;
            dp_start_q  <= 1'b0;
            result_we_q <= 1'b0;
            dp_abort_q  <= 1'b0;
        end else begin
            dp_start_q  <= 1'b0;
            result_we_q <= 1'b0;
            dp_abort_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (deaccel_factor_we_i) begin
                        deaccel_q <= deaccel_factor_i;
                    end
                    if (op_sel_we_i && !op_legal(op_sel_i)) begin
                        state_q    <= S_ERROR;
                        status_q   <= ST_ERROR;
                        err_code_q <= ERR_ILLEGAL;
                    end else begin
                        if (op_sel_we_i) begin
                            op_sel_q <= op_sel_i;
                        end
                        if (trigger_i) begin
                            state_q    <= S_ISSUE;
                            status_q   <= ST_BUSY;
                            dp_start_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    busy_viol_q <= busy_viol_d;
                    to_cnt_q    <= '0;
                    state_q     <= S_WAIT_DP;
                end
                S_WAIT_DP: begin
                    busy_viol_q <= busy_viol_d;
                    // A completion on the expiry cycle takes priority over the timeout.
                    if (dp_valid_i) begin
                        if (dp_err_i) begin
                            state_q    <= S_ERROR;
                            status_q   <= ST_ERROR;
                            err_code_q <= ERR_DP;
                        end else begin
                            state_q     <= S_DELAY;
                            delay_cnt_q <= deaccel_q;
                            result_we_q <= (deaccel_q == '0);
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q    <= S_ERROR;
                        status_q   <= ST_ERROR;
                        err_code_q <= ERR_TIMEOUT;
                        dp_abort_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_DELAY: begin
                    busy_viol_q <= busy_viol_d;
                    // Count zero marks the commit cycle itself; leave on the following edge.
                    if (delay_cnt_q == '0) begin
                        if (busy_viol_d) begin
                            state_q    <= S_ERROR;
                            status_q   <= ST_ERROR;
                            err_code_q <= ERR_BUSY;
                        end else begin
                            state_q  <= S_IDLE;
                            status_q <= ST_IDLE;
                        end
                    end else begin
                        delay_cnt_q <= delay_cnt_q - D_ONE;
                        result_we_q <= (delay_cnt_q == D_ONE);
                    end
                end
                S_ERROR: begin
                    if (clear_err_i) begin
                        state_q     <= S_IDLE;
                        status_q    <= ST_IDLE;
                        err_code_q  <= ERR_NONE;
                        busy_viol_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    status_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_sel_o         = op_sel_q;
    assign deaccel_factor_o = deaccel_q;
    assign dp_op_o          = op_sel_q;
    assign dp_start_o       = dp_start_q;
    assign result_we_o      = result_we_q;
    assign dp_abort_o       = dp_abort_q;
    assign status_o         = status_q;
    assign err_code_o       = err_code_q;

endmodule

// File: tb/tb_wide_alu_ctrl.sv
// Directed bench for wide_alu_ctrl: hand-computed timing of start, commit, abort and status.
module tb_wide_alu_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       trigger_i;
    logic       clear_err_i;
    logic       op_sel_we_i;
    logic [2:0] op_sel_i;
    logic [2:0] op_sel_o;
    logic       deaccel_factor_we_i;
    logic [7:0] deaccel_factor_i;
    logic [7:0] deaccel_factor_o;
    logic       dp_start_o;
    logic [2:0] dp_op_o;
    logic       dp_abort_o;
    logic       dp_valid_i;
    logic       dp_err_i;
    logic       result_we_o;
    logic [1:0] status_o;
    logic [2:0] err_code_o;

    int checks = 0;
    int errors = 0;

    wide_alu_ctrl #(
        .OP_SEL_WIDTH  (3),
        .NUM_OPS       (5),
        .DEACCEL_WIDTH (8),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .trigger_i          (trigger_i),
        .clear_err_i        (clear_err_i),
        .op_sel_we_i        (op_sel_we_i),
        .op_sel_i           (op_sel_i),
        .op_sel_o           (op_sel_o),
        .deaccel_factor_we_i(deaccel_factor_we_i),
        .deaccel_factor_i   (deaccel_factor_i),
        .deaccel_factor_o   (deaccel_factor_o),
        .dp_start_o         (dp_start_o),
        .dp_op_o            (dp_op_o),
        .dp_abort_o         (dp_abort_o),
        .dp_valid_i         (dp_valid_i),
        .dp_err_i           (dp_err_i),
        .result_we_o        (result_we_o),
        .status_o           (status_o),
        .err_code_o         (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        trigger_i           = 1'b0;
        clear_err_i         = 1'b0;
        op_sel_we_i         = 1'b0;
        op_sel_i            = 3'd0;
        deaccel_factor_we_i = 1'b0;
        deaccel_factor_i    = 8'd0;
        dp_valid_i          = 1'b0;
        dp_err_i            = 1'b0;
    endtask

    // Caller has set trigger (and any writes) for the current cycle; returns in the first WAIT_DP cycle.
    task automatic issue(input string tag, input logic [2:0] exp_op);
        tick();
        idle_inputs();
        chk({tag, "_start"}, dp_start_o, 1);
        chk({tag, "_op"}, dp_op_o, exp_op);
        chk({tag, "_busy"}, status_o, 2'b01);
        tick();
    endtask

    // dp_valid_i is asserted in the current cycle; counts cycles until result_we_o.
    task automatic count_to_result(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        do begin
            tick();
            dp_valid_i = 1'b0;
            n++;
            if (status_o !== 2'b01) busy_ok = 1'b0;
        end while (result_we_o !== 1'b1 && n < 2000);
    endtask

    initial begin
        int n;
        bit busy_ok;
        int pulses;

        idle_inputs();
        rst_ni = 1'b0;
        repeat (3) tick();
        chk("rst_status", status_o, 2'b00);
        chk("rst_err", err_code_o, 0);
        chk("rst_pulses", {dp_start_o, result_we_o, dp_abort_o}, 0);
        chk("rst_op", {op_sel_o, dp_op_o}, 0);
        chk("rst_deaccel", deaccel_factor_o, 0);
        rst_ni = 1'b1;
        tick();

        // Basic run: writes and trigger in the same cycle, valid two cycles into WAIT_DP.
        op_sel_we_i = 1'b1; op_sel_i = 3'd2;
        deaccel_factor_we_i = 1'b1; deaccel_factor_i = 8'd0;
        trigger_i = 1'b1;
        issue("basic", 3'd2);
        chk("basic_wait_busy", status_o, 2'b01);
        tick();
        chk("basic_no_early_we", result_we_o, 0);
        dp_valid_i = 1'b1;
        tick();
        dp_valid_i = 1'b0;
        chk("basic_we", result_we_o, 1);
        chk("basic_we_busy", status_o, 2'b01);
        tick();
        chk("basic_idle", status_o, 2'b00);
        chk("basic_we_done", result_we_o, 0);

        // De-acceleration of 5: commit six cycles after valid.
        deaccel_factor_we_i = 1'b1; deaccel_factor_i = 8'd5;
        trigger_i = 1'b1;
        issue("d5", 3'd2);
        tick();
        dp_valid_i = 1'b1;
        count_to_result(n, busy_ok);
        chk("d5_latency", n, 6);
        chk("d5_busy_held", busy_ok, 1);
        tick();
        chk("d5_idle", status_o, 2'b00);

        // Illegal op select.
        op_sel_we_i = 1'b1; op_sel_i = 3'd6;
        tick();
        idle_inputs();
        chk("ill_op_kept", op_sel_o, 2);
        chk("ill_status", status_o, 2'b10);
        chk("ill_code", err_code_o, 1);
        trigger_i = 1'b1;
        op_sel_we_i = 1'b1; op_sel_i = 3'd1;
        tick();
        idle_inputs();
        chk("err_trig_ignored", dp_start_o, 0);
        chk("err_write_ignored", op_sel_o, 2);
        clear_err_i = 1'b1;
        tick();
        idle_inputs();
        chk("clr_status", status_o, 2'b00);
        chk("clr_code", err_code_o, 0);
        deaccel_factor_we_i = 1'b1; deaccel_factor_i = 8'd0;
        trigger_i = 1'b1;
        issue("after_clr", 3'd2);
        dp_valid_i = 1'b1;
        count_to_result(n, busy_ok);
        chk("after_clr_latency", n, 1);
        tick();
        chk("after_clr_idle", status_o, 2'b00);

        // Busy violation during WAIT_DP.
        trigger_i = 1'b1;
        issue("viol", 3'd2);
        trigger_i = 1'b1;
        deaccel_factor_we_i = 1'b1; deaccel_factor_i = 8'd9;
        tick();
        idle_inputs();
        chk("viol_deaccel_kept", deaccel_factor_o, 0);
        chk("viol_no_start", dp_start_o, 0);
        chk("viol_still_busy", status_o, 2'b01);
        dp_valid_i = 1'b1;
        count_to_result(n, busy_ok);
        chk("viol_commit", n, 1);
        tick();
        chk("viol_status", status_o, 2'b10);
        chk("viol_code", err_code_o, 2);
        clear_err_i = 1'b1;
        tick();
        idle_inputs();
        chk("viol_clr", status_o, 2'b00);

        // Timeout: abort exactly 1024 cycles after entering WAIT_DP.
        trigger_i = 1'b1;
        issue("to", 3'd2);
        n = 0;
        while (dp_abort_o !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("to_latency", n, 1024);
        chk("to_status", status_o, 2'b10);
        chk("to_code", err_code_o, 4);
        chk("to_no_we", result_we_o, 0);
        clear_err_i = 1'b1;
        tick();
        idle_inputs();

        // Valid on the expiry cycle wins over timeout.
        trigger_i = 1'b1;
        issue("exp", 3'd2);
        repeat (1023) tick();
        chk("exp_no_abort", {dp_abort_o, status_o}, 3'b001);
        dp_valid_i = 1'b1;
        count_to_result(n, busy_ok);
        chk("exp_commit", n, 1);
        chk("exp_busy", busy_ok, 1);
        tick();
        chk("exp_idle", {status_o, err_code_o}, 0);

        // Datapath error.
        trigger_i = 1'b1;
        issue("dperr", 3'd2);
        dp_valid_i = 1'b1; dp_err_i = 1'b1;
        tick();
        idle_inputs();
        chk("dperr_status", status_o, 2'b10);
        chk("dperr_code", err_code_o, 3);
        chk("dperr_no_we", result_we_o, 0);
        clear_err_i = 1'b1;
        tick();
        idle_inputs();

        // Reset while stretching the commit.
        deaccel_factor_we_i = 1'b1; deaccel_factor_i = 8'd5;
        trigger_i = 1'b1;
        issue("rstd", 3'd2);
        dp_valid_i = 1'b1;
        tick();
        idle_inputs();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("rstd_status", status_o, 2'b00);
        chk("rstd_regs", {op_sel_o, dp_op_o, deaccel_factor_o}, 0);
        chk("rstd_pulses", {dp_start_o, result_we_o, dp_abort_o}, 0);
        tick();
        rst_ni = 1'b1;
        pulses = 0;
        repeat (10) begin
            tick();
            if (result_we_o || dp_start_o || dp_abort_o) pulses++;
        end
        chk("rstd_no_pulse", pulses, 0);
        chk("rstd_idle", status_o, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
